// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetcher feeding a 2-entry instruction buffer.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr_bits,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
`ifdef IFU_MISALIGN_CHECK_EN
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_DRAIN = 2'd2
`endif
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic [XLEN-1:0] req_addr_r;
  logic [XLEN-1:0] redirect_tgt_s;
  logic [XLEN-1:0] fifo_data_r [2];
  logic [XLEN-1:0] fifo_addr_r [2];
  logic            rd_ptr_r, wr_ptr_r;
  logic [1:0]      count_r;
  logic            accept_s, push_s, pop_s, outstanding_s;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_r, fault_nxt_s, misalign_s;
  assign misalign_s     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt_s = redirect_pc;
  assign fetch_fault    = fault_r;
`else
  logic unused_redirect_low_s;
  assign unused_redirect_low_s = ^redirect_pc[1:0];
  assign redirect_tgt_s        = {redirect_pc[XLEN-1:2], 2'b00};
  assign fetch_fault           = 1'b0;
`endif

  // Request and buffer-head outputs, all derived from registered state.
  always_comb begin
    imem_req_valid = !reset && (state_r == ST_FETCH) && (count_r != 2'd2);
    imem_req_addr  = pc_r;
    out_valid      = (count_r != 2'd0);
    out_instr_bits = fifo_data_r[rd_ptr_r];
    out_pc         = fifo_addr_r[rd_ptr_r];
  end

  assign accept_s = imem_req_valid && imem_req_ready;
  assign pop_s    = out_valid && out_ready && !redirect_valid;

  // Next-state, PC and push decode; a redirect overrides everything else.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    push_s        = 1'b0;
    outstanding_s = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    fault_nxt_s   = fault_r;
`endif
    case (state_r)
      ST_FETCH: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT;
          pc_nxt_s    = pc_r + PC_STEP;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt_s = ST_FETCH;
          push_s      = 1'b1;
        end else begin
          outstanding_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
`ifdef IFU_MISALIGN_CHECK_EN
          state_nxt_s = fault_r ? ST_FAULT : ST_FETCH;
`else
          state_nxt_s = ST_FETCH;
`endif
        end else begin
          outstanding_s = 1'b1;
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
`endif
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase

    // A response already in flight (or accepted this cycle) must be drained.
    if (redirect_valid) begin
      push_s   = 1'b0;
      pc_nxt_s = redirect_tgt_s;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_nxt_s = misalign_s;
`endif
      if (outstanding_s || accept_s) begin
        state_nxt_s = ST_DRAIN;
`ifdef IFU_MISALIGN_CHECK_EN
      end else if (misalign_s) begin
        state_nxt_s = ST_FAULT;
`endif
      end else begin
        state_nxt_s = ST_FETCH;
      end
    end else begin
      pc_nxt_s = pc_nxt_s;
    end
  end

  // Control state, fetch PC and address of the outstanding request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      req_addr_r <= {XLEN{1'b0}};
`ifdef IFU_MISALIGN_CHECK_EN
      fault_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (accept_s) begin
        req_addr_r <= pc_r;
      end
`ifdef IFU_MISALIGN_CHECK_EN
      fault_r <= fault_nxt_s;
`endif
    end
  end

  // Two-entry instruction buffer; a redirect flushes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_r[i] <= {XLEN{1'b0}};
        fifo_addr_r[i] <= {XLEN{1'b0}};
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= imem_resp_data;
        fifo_addr_r[wr_ptr_r] <= req_addr_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit plus hand-written corner sequences.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr_bits;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr_bits(out_instr_bits), .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs [34];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic redir,
                              logic [31:0] rpc, logic ordy, logic e_req, logic [31:0] e_addr,
                              logic e_ov, logic [31:0] e_instr, logic [31:0] e_pc, logic e_fault);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.ordy = ordy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic redir, input logic [31:0] rpc, input logic ordy);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    out_ready       = ordy;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    //                 rdy   rv    resp_data      redir rpc            ordy  req   addr           ov    instr          pc             fault
    vecs[0]  = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 32'h1000_0000, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0004, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h1000_0000, 32'h0000_0000, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 32'h1000_0004, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h1000_0004, 32'h0000_0004, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 32'h1000_0008, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_000C, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h1000_0008, 32'h0000_0008, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 32'h1000_000C, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h1000_0008, 32'h0000_0008, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h1000_0008, 32'h0000_0008, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h1000_0008, 32'h0000_0008, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h1000_0008, 32'h0000_0008, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h1000_000C, 32'h0000_000C, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[15] = mk(1'b1, 1'b1, 32'h1000_0010, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0014, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h1000_0010, 32'h0000_0010, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0018, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[18] = mk(1'b1, 1'b1, 32'h1000_0014, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[20] = mk(1'b1, 1'b1, 32'h2000_0100, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0104, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h2000_0100, 32'h0000_0100, 1'b0);
    vecs[22] = mk(1'b1, 1'b1, 32'h2000_0104, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[23] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0102, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0,         1'b0);
`ifdef IFU_MISALIGN_CHECK_EN
    vecs[24] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0102, 1'b0, 32'h0,         32'h0,         1'b1);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0102, 1'b0, 32'h0,         32'h0,         1'b1);
`else
    vecs[24] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'h0,         1'b0);
`endif
    vecs[26] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[27] = mk(1'b1, 1'b1, 32'h3000_0200, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0204, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[28] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0204, 1'b1, 32'h3000_0200, 32'h0000_0200, 1'b0);
    vecs[29] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[30] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[31] = mk(1'b1, 1'b1, 32'h4FFF_FFFC, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0);
    vecs[32] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h4FFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    vecs[33] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0);

    // Reset with a stray response that must be ignored.
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr_bits, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].redir, vecs[i].rpc, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].e_fault});
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_out_instr", i), out_instr_bits, vecs[i].e_instr);
        check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
      end
      step();
    end

    // Redirect arriving together with the outstanding response: no drain needed.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 check("hs1_req_valid0", {31'd0, imem_req_valid}, 32'd1);
    step();
    drive(1'b0, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0300, 1'b0);
    #1 check("hs1_wait_req", {31'd0, imem_req_valid}, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("hs1_reissue_valid", {31'd0, imem_req_valid}, 32'd1);
    check("hs1_reissue_addr", imem_req_addr, 32'h0000_0300);
    check("hs1_discarded", {31'd0, out_valid}, 32'd0);
    step();
    drive(1'b0, 1'b1, 32'h6000_0300, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("hs1_out_valid", {31'd0, out_valid}, 32'd1);
    check("hs1_out_instr", out_instr_bits, 32'h6000_0300);
    check("hs1_out_pc", out_pc, 32'h0000_0300);

    // Reset in mid-run with the buffer occupied.
    reset = 1'b1;
    #1 check("hs2_req_in_reset", {31'd0, imem_req_valid}, 32'd0);
    step();
    check("hs2_out_valid", {31'd0, out_valid}, 32'd0);
    check("hs2_out_instr", out_instr_bits, 32'h0);
    check("hs2_out_pc", out_pc, 32'h0);
    reset = 1'b0;
    #1;
    check("hs2_first_req", {31'd0, imem_req_valid}, 32'd1);
    check("hs2_first_addr", imem_req_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
